// File: rtl/axi_bridge_arb_pkg.sv
// Shared encodings for the cache-to-AXI bridge: request types, AXI ids,
// FSM state codes and the len/size mapping used by both read and write paths.
package axi_bridge_arb_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam int ID_INST = 0;
  localparam int ID_DATA = 1;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_SEND = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;

  // Line requests become a full INCR burst of 32-bit beats; anything else is one beat.
  function automatic logic [7:0] axi_len(input logic [2:0] t, input int line_words);
    return (t == TYPE_LINE) ? 8'(line_words - 1) : 8'd0;
  endfunction

  function automatic logic [2:0] axi_size(input logic [2:0] t);
    return (t == TYPE_LINE) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/axi_wr_ctrl.sv
// Write channel controller: accepts one dcache write, drives AW and W
// independently, then waits for the B response before accepting the next.
module axi_wr_ctrl
  import axi_bridge_arb_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic [2:0]              wr_type,
  input  logic [31:0]             wr_addr,
  input  logic [3:0]              wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                    wr_rdy,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic                    bvalid,
  output logic                    bready,
  output logic                    busy,
  output logic [27:0]             busy_line,
  output logic [1:0]              state
);

  localparam int CNT_W = $clog2(LINE_WORDS);

  logic [1:0]                state_q;
  logic [31:0]               addr_q;
  logic [2:0]                type_q;
  logic [3:0]                wstrb_q;
  logic [32*LINE_WORDS-1:0]  data_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      aw_done_q, w_done_q;
  logic                      wr_acc, aw_fire, w_fire, aw_done_nxt, w_done_nxt;

  assign wr_rdy    = ~rst & (state_q == W_IDLE);
  assign wr_acc    = wr_req & wr_rdy;
  assign awaddr    = addr_q;
  assign awlen     = axi_len(type_q, LINE_WORDS);
  assign awsize    = axi_size(type_q);
  assign awvalid   = ~rst & (state_q == W_SEND) & ~aw_done_q;
  assign wvalid    = ~rst & (state_q == W_SEND) & ~w_done_q;
  assign wdata     = data_q[{cnt_q, 5'd0} +: 32];
  assign wstrb     = (type_q == TYPE_LINE) ? 4'hF : wstrb_q;
  assign wlast     = (8'(cnt_q) == awlen);
  assign bready    = ~rst & (state_q == W_B);
  assign busy      = (state_q != W_IDLE);
  assign busy_line = addr_q[31:4];
  assign state     = state_q;

  assign aw_fire     = awvalid & awready;
  assign w_fire      = wvalid & wready;
  assign aw_done_nxt = aw_done_q | aw_fire;
  assign w_done_nxt  = w_done_q | (w_fire & wlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= W_IDLE;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        W_IDLE: if (wr_acc) begin
          addr_q    <= wr_addr;
          type_q    <= wr_type;
          wstrb_q   <= wr_wstrb;
          data_q    <= wr_data;
          cnt_q     <= '0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= W_SEND;
        end
        W_SEND: begin
          aw_done_q <= aw_done_nxt;
          w_done_q  <= w_done_nxt;
          if (w_fire && !wlast) cnt_q <= cnt_q + 1'b1;
          // The completing handshake of either channel counts in the same cycle.
          if (aw_done_nxt && w_done_nxt) state_q <= W_B;
        end
        W_B: if (bvalid) state_q <= W_IDLE;
        default: state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axi_bridge_arb.sv
// Shared AXI3 master for icache reads and dcache reads/writes: one read and one
// write outstanding, data reads win arbitration, same-line reads wait for writes.
module axi_bridge_arb
  import axi_bridge_arb_pkg::*;
#(
  parameter int ID_W       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_rd_req,
  input  logic [2:0]               inst_rd_type,
  input  logic [31:0]              inst_rd_addr,
  output logic                     inst_rd_rdy,
  output logic                     inst_ret_valid,
  output logic                     inst_ret_last,
  output logic [31:0]              inst_ret_data,
  input  logic                     data_rd_req,
  input  logic [2:0]               data_rd_type,
  input  logic [31:0]              data_rd_addr,
  output logic                     data_rd_rdy,
  output logic                     data_ret_valid,
  output logic                     data_ret_last,
  output logic [31:0]              data_ret_data,
  input  logic                     data_wr_req,
  input  logic [2:0]               data_wr_type,
  input  logic [31:0]              data_wr_addr,
  input  logic [3:0]               data_wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] data_wr_data,
  output logic                     data_wr_rdy,
  output logic [ID_W-1:0]          arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ID_W-1:0]          awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ID_W-1:0]          wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [1:0]               rd_state,
  output logic [1:0]               wr_state
);

  // Handshakes: a transfer occurs on a cycle where valid/req and ready/rdy are both
  // high; a raised valid stays high with a stable payload until that transfer.

  logic [1:0]      rd_state_q;
  logic [ID_W-1:0] rid_q;
  logic [31:0]     raddr_q;
  logic [7:0]      rlen_q;
  logic [2:0]      rsize_q;
  logic            wr_busy;
  logic [27:0]     wr_line;
  logic            raw_hit, data_elig, rd_idle, data_acc, inst_acc, inst_sel, data_sel;

  assign raw_hit = (wr_busy && (wr_line == data_rd_addr[31:4])) ||
                   (data_wr_req && data_wr_rdy && (data_wr_addr[31:4] == data_rd_addr[31:4]));
  assign rd_idle     = ~rst & (rd_state_q == R_IDLE);
  assign data_elig   = data_rd_req & ~raw_hit;
  assign data_rd_rdy = rd_idle & data_elig;
  assign inst_rd_rdy = rd_idle & ~data_elig;
  assign data_acc    = data_rd_req & data_rd_rdy;
  assign inst_acc    = inst_rd_req & inst_rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (data_acc) begin
            rid_q      <= ID_W'(ID_DATA);
            raddr_q    <= data_rd_addr;
            rlen_q     <= axi_len(data_rd_type, LINE_WORDS);
            rsize_q    <= axi_size(data_rd_type);
            rd_state_q <= R_AR;
          end else if (inst_acc) begin
            rid_q      <= ID_W'(ID_INST);
            raddr_q    <= inst_rd_addr;
            rlen_q     <= axi_len(inst_rd_type, LINE_WORDS);
            rsize_q    <= axi_size(inst_rd_type);
            rd_state_q <= R_AR;
          end
        end
        R_AR:    if (arready) rd_state_q <= R_R;
        R_R:     if (rvalid && rlast) rd_state_q <= R_IDLE;
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign arid    = rid_q;
  assign araddr  = raddr_q;
  assign arlen   = rlen_q;
  assign arsize  = rsize_q;
  assign arvalid = ~rst & (rd_state_q == R_AR);
  assign rready  = ~rst & (rd_state_q == R_R);
  assign rd_state = rd_state_q;

  // Return beats pass straight through to whichever cache owns the id.
  assign inst_sel       = rready & rvalid & (rid == ID_W'(ID_INST));
  assign data_sel       = rready & rvalid & (rid == ID_W'(ID_DATA));
  assign inst_ret_valid = inst_sel;
  assign inst_ret_last  = inst_sel & rlast;
  assign inst_ret_data  = rdata;
  assign data_ret_valid = data_sel;
  assign data_ret_last  = data_sel & rlast;
  assign data_ret_data  = rdata;

  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awid    = ID_W'(ID_DATA);
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = ID_W'(ID_DATA);

  axi_wr_ctrl #(.LINE_WORDS(LINE_WORDS)) u_wr (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (data_wr_req),
    .wr_type   (data_wr_type),
    .wr_addr   (data_wr_addr),
    .wr_wstrb  (data_wr_wstrb),
    .wr_data   (data_wr_data),
    .wr_rdy    (data_wr_rdy),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bvalid    (bvalid),
    .bready    (bready),
    .busy      (wr_busy),
    .busy_line (wr_line),
    .state     (wr_state)
  );

endmodule

// File: tb/tb_axi_bridge_arb.sv
// Scenario bench for axi_bridge_arb: a hand-driven AXI slave, expected return
// and write beats queued as stimulus is driven and popped by negedge monitors.
module tb_axi_bridge_arb;
  import axi_bridge_arb_pkg::*;

  localparam int ID_W = 4;
  localparam int LINE_WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  logic inst_rd_req, inst_rd_rdy, inst_ret_valid, inst_ret_last;
  logic [2:0] inst_rd_type;
  logic [31:0] inst_rd_addr, inst_ret_data;
  logic data_rd_req, data_rd_rdy, data_ret_valid, data_ret_last;
  logic [2:0] data_rd_type;
  logic [31:0] data_rd_addr, data_ret_data;
  logic data_wr_req, data_wr_rdy;
  logic [2:0] data_wr_type;
  logic [31:0] data_wr_addr;
  logic [3:0] data_wr_wstrb;
  logic [127:0] data_wr_data;
  logic [ID_W-1:0] arid, rid, awid, wid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rd_state, wr_state;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;

  int errors = 0;
  int checks = 0;
  logic [32:0] inst_q[$];
  logic [32:0] data_q[$];
  logic [36:0] w_q[$];
  logic [32:0] mon_i, mon_d;
  logic [36:0] mon_w;

  always #5 clk = ~clk;

  axi_bridge_arb #(.ID_W(ID_W), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .data_ret_data(data_ret_data),
    .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
    .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .rd_state(rd_state), .wr_state(wr_state)
  );

  // Scoreboard monitors: every observed beat must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_ret_valid) begin
        checks++;
        if (inst_q.size() == 0) begin
          errors++; $display("FAIL inst_ret unexpected beat: got %h, queue empty", inst_ret_data);
        end else begin
          mon_i = inst_q.pop_front();
          if ({inst_ret_last, inst_ret_data} !== mon_i) begin
            errors++; $display("FAIL inst_ret beat: got %h exp %h", {inst_ret_last, inst_ret_data}, mon_i);
          end
        end
      end
      if (data_ret_valid) begin
        checks++;
        if (data_q.size() == 0) begin
          errors++; $display("FAIL data_ret unexpected beat: got %h, queue empty", data_ret_data);
        end else begin
          mon_d = data_q.pop_front();
          if ({data_ret_last, data_ret_data} !== mon_d) begin
            errors++; $display("FAIL data_ret beat: got %h exp %h", {data_ret_last, data_ret_data}, mon_d);
          end
        end
      end
      if (wvalid && wready) begin
        checks++;
        if (w_q.size() == 0) begin
          errors++; $display("FAIL w_beat unexpected: got %h, queue empty", wdata);
        end else begin
          mon_w = w_q.pop_front();
          if ({wlast, wstrb, wdata} !== mon_w) begin
            errors++; $display("FAIL w_beat: got %h exp %h", {wlast, wstrb, wdata}, mon_w);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs;
    inst_rd_req = 0; inst_rd_type = TYPE_WORD; inst_rd_addr = '0;
    data_rd_req = 0; data_rd_type = TYPE_WORD; data_rd_addr = '0;
    data_wr_req = 0; data_wr_type = TYPE_WORD; data_wr_addr = '0;
    data_wr_wstrb = '0; data_wr_data = '0;
    arready = 0; rid = '0; rdata = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  // Slave side of one read: accept AR (bounded wait) then return the beats.
  task automatic serve_read(input logic [ID_W-1:0] id, input int beats);
    int n = 0;
    logic [31:0] d;
    while (!arvalid && n < 10) begin tick; n++; end
    checks++;
    if (arvalid !== 1'b1 || arid !== id) begin
      errors++; $display("FAIL serve_read_ar: arvalid=%b arid=%0d exp 1/%0d", arvalid, arid, id);
    end
    arready = 1; tick; arready = 0;
    for (int i = 0; i < beats; i++) begin
      d = $urandom;
      if (id == ID_W'(ID_INST)) inst_q.push_back({(i == beats - 1), d});
      else data_q.push_back({(i == beats - 1), d});
      rid = id; rdata = d; rlast = (i == beats - 1); rvalid = 1;
      tick;
    end
    rvalid = 0; rlast = 0;
  endtask

  task automatic test_reset;
    clear_inputs;
    rst = 1;
    inst_rd_req = 1; data_rd_req = 1; data_wr_req = 1; rvalid = 1; bvalid = 1;
    repeat (2) tick;
    checks++;
    if ({inst_rd_rdy, data_rd_rdy, data_wr_rdy, arvalid, rready, awvalid, wvalid, bready,
         inst_ret_valid, data_ret_valid} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs: some valid/ready high during rst");
    end
    clear_inputs;
    rst = 0; #1;
    checks++;
    if ({inst_rd_rdy, data_wr_rdy, data_rd_rdy, rd_state, wr_state} !== {3'b110, R_IDLE, W_IDLE}) begin
      errors++; $display("FAIL reset_idle: got %b exp %b", {inst_rd_rdy, data_wr_rdy, data_rd_rdy, rd_state, wr_state}, {3'b110, R_IDLE, W_IDLE});
    end
    checks++;
    if ({arburst, awburst, arcache, awid, wid} !== {2'b01, 2'b01, 4'b0000, 4'd1, 4'd1}) begin
      errors++; $display("FAIL tied_fields: got %h", {arburst, awburst, arcache, awid, wid});
    end
  endtask

  task automatic test_inst_line;
    logic [31:0] d;
    tick;
    inst_rd_req = 1; inst_rd_type = TYPE_LINE; inst_rd_addr = 32'h1C00_0000; #1;
    checks++;
    if (inst_rd_rdy !== 1'b1) begin errors++; $display("FAIL inst_line_rdy: got %b exp 1", inst_rd_rdy); end
    tick; inst_rd_req = 0; #1;
    checks++;
    if ({arvalid, arid, araddr, arlen, arsize, rready} !== {1'b1, 4'd0, 32'h1C00_0000, 8'd3, 3'd2, 1'b0}) begin
      errors++; $display("FAIL inst_line_ar: got %h exp %h", {arvalid, arid, araddr, arlen, arsize, rready},
                         {1'b1, 4'd0, 32'h1C00_0000, 8'd3, 3'd2, 1'b0});
    end
    arready = 1; tick; arready = 0; #1;
    checks++;
    if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL inst_line_rr: got %b exp 01", {arvalid, rready}); end
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      inst_q.push_back({(i == 3), d});
      rid = 0; rdata = d; rlast = (i == 3); rvalid = 1;
      tick;
    end
    rvalid = 0; rlast = 0; #1;
    checks++;
    if ({rd_state, inst_q.size() == 0} !== {R_IDLE, 1'b1}) begin
      errors++; $display("FAIL inst_line_done: state=%0d left=%0d exp 0/0", rd_state, inst_q.size());
    end
  endtask

  task automatic test_arb;
    inst_rd_req = 1; inst_rd_type = TYPE_WORD; inst_rd_addr = 32'h0000_0100;
    data_rd_req = 1; data_rd_type = TYPE_WORD; data_rd_addr = 32'h0000_0200; #1;
    checks++;
    if ({data_rd_rdy, inst_rd_rdy} !== 2'b10) begin errors++; $display("FAIL arb_grant: got %b exp 10", {data_rd_rdy, inst_rd_rdy}); end
    tick; data_rd_req = 0; #1;
    checks++;
    if ({arvalid, arid, araddr, arlen, arsize, inst_rd_rdy} !== {1'b1, 4'd1, 32'h200, 8'd0, 3'd2, 1'b0}) begin
      errors++; $display("FAIL arb_data_ar: got %h exp %h", {arvalid, arid, araddr, arlen, arsize, inst_rd_rdy},
                         {1'b1, 4'd1, 32'h200, 8'd0, 3'd2, 1'b0});
    end
    serve_read(4'd1, 1); #1;
    checks++;
    if (inst_rd_rdy !== 1'b1) begin errors++; $display("FAIL arb_inst_after: got %b exp 1", inst_rd_rdy); end
    tick; inst_rd_req = 0; #1;
    checks++;
    if ({arid, araddr} !== {4'd0, 32'h100}) begin errors++; $display("FAIL arb_inst_ar: got %h exp %h", {arid, araddr}, {4'd0, 32'h100}); end
    serve_read(4'd0, 1);
  endtask

  task automatic test_write_line;
    logic [31:0] w[4];
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; w_q.push_back({(i == 3), 4'hF, w[i]}); end
    data_wr_req = 1; data_wr_type = TYPE_LINE; data_wr_addr = 32'h0000_1040;
    data_wr_data = {w[3], w[2], w[1], w[0]}; data_wr_wstrb = 4'h0; #1;
    checks++;
    if (data_wr_rdy !== 1'b1) begin errors++; $display("FAIL wr_line_rdy: got %b exp 1", data_wr_rdy); end
    wready = 1; awready = 0;
    tick; data_wr_req = 0; #1;
    checks++;
    if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h1040, 8'd3, 3'd2}) begin
      errors++; $display("FAIL wr_line_aw: got %h exp %h", {awvalid, awaddr, awlen, awsize}, {1'b1, 32'h1040, 8'd3, 3'd2});
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({awvalid, bready} !== 2'b10) begin errors++; $display("FAIL wr_line_wait%0d: got %b exp 10", c, {awvalid, bready}); end
      tick;
    end
    checks++;
    if ({awvalid, wvalid, bready, data_wr_rdy} !== 4'b1000) begin
      errors++; $display("FAIL wr_line_wdone: got %b exp 1000", {awvalid, wvalid, bready, data_wr_rdy});
    end
    awready = 1; tick; awready = 0; #1;
    checks++;
    if ({awvalid, wvalid, bready, wr_state} !== {3'b001, W_B}) begin
      errors++; $display("FAIL wr_line_b: got %b exp %b", {awvalid, wvalid, bready, wr_state}, {3'b001, W_B});
    end
    bvalid = 1; #1;
    checks++;
    if (data_wr_rdy !== 1'b0) begin errors++; $display("FAIL wr_line_rdy_b: got %b exp 0", data_wr_rdy); end
    tick; bvalid = 0; wready = 0; #1;
    checks++;
    if (data_wr_rdy !== 1'b1) begin errors++; $display("FAIL wr_line_rdy_end: got %b exp 1", data_wr_rdy); end
  endtask

  task automatic test_raw;
    logic [31:0] w[4];
    for (int i = 0; i < 4; i++) begin w[i] = $urandom; w_q.push_back({(i == 3), 4'hF, w[i]}); end
    data_wr_req = 1; data_wr_type = TYPE_LINE; data_wr_addr = 32'h0000_1040; data_wr_data = {w[3], w[2], w[1], w[0]};
    data_rd_req = 1; data_rd_type = TYPE_WORD; data_rd_addr = 32'h0000_1048; #1;
    checks++;
    if ({data_wr_rdy, data_rd_rdy, inst_rd_rdy} !== 3'b101) begin
      errors++; $display("FAIL raw_same_cycle: got %b exp 101", {data_wr_rdy, data_rd_rdy, inst_rd_rdy});
    end
    awready = 0; wready = 0;
    tick; data_wr_req = 0; #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (data_rd_rdy !== 1'b0) begin errors++; $display("FAIL raw_blocked%0d: got %b exp 0", c, data_rd_rdy); end
      tick;
    end
    data_rd_addr = 32'h0000_2000; #1;
    checks++;
    if (data_rd_rdy !== 1'b1) begin errors++; $display("FAIL raw_other_line: got %b exp 1", data_rd_rdy); end
    tick; data_rd_req = 0; #1;
    checks++;
    if (araddr !== 32'h2000) begin errors++; $display("FAIL raw_other_ar: got %h exp 2000", araddr); end
    serve_read(4'd1, 1);
    data_rd_req = 1; data_rd_addr = 32'h0000_1048; #1;
    checks++;
    if (data_rd_rdy !== 1'b0) begin errors++; $display("FAIL raw_still_blocked: got %b exp 0", data_rd_rdy); end
    awready = 1; wready = 1;
    tick; awready = 0;
    repeat (3) tick;
    wready = 0; bvalid = 1; #1;
    checks++;
    if ({wr_state, data_rd_rdy} !== {W_B, 1'b0}) begin
      errors++; $display("FAIL raw_in_b: got %b exp %b", {wr_state, data_rd_rdy}, {W_B, 1'b0});
    end
    tick; bvalid = 0; #1;
    checks++;
    if (data_rd_rdy !== 1'b1) begin errors++; $display("FAIL raw_released: got %b exp 1", data_rd_rdy); end
    tick; data_rd_req = 0;
    serve_read(4'd1, 1);
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    d = $urandom;
    w_q.push_back({1'b1, 4'b0010, d});
    data_wr_req = 1; data_wr_type = TYPE_BYTE; data_wr_addr = 32'h0000_0008; data_wr_wstrb = 4'b0010;
    data_wr_data = {32'($urandom), 32'($urandom), 32'($urandom), d};
    awready = 1; wready = 1;
    tick; data_wr_req = 0; #1;
    checks++;
    if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'h8, 8'd0, 3'd0}) begin
      errors++; $display("FAIL byte_aw: got %h exp %h", {awvalid, awaddr, awlen, awsize}, {1'b1, 32'h8, 8'd0, 3'd0});
    end
    checks++;
    if ({wvalid, wstrb, wlast} !== {1'b1, 4'b0010, 1'b1}) begin
      errors++; $display("FAIL byte_w: got %b exp 1_0010_1", {wvalid, wstrb, wlast});
    end
    tick; awready = 0; wready = 0; #1;
    checks++;
    if (bready !== 1'b1) begin errors++; $display("FAIL byte_bready: got %b exp 1", bready); end
    bvalid = 1; tick; bvalid = 0; #1;
    checks++;
    if (data_wr_rdy !== 1'b1) begin errors++; $display("FAIL byte_done: got %b exp 1", data_wr_rdy); end
  endtask

  task automatic test_reset_mid;
    inst_rd_req = 1; inst_rd_type = TYPE_LINE; inst_rd_addr = 32'h1C00_0040;
    tick; inst_rd_req = 0; arready = 1;
    tick; arready = 0;
    data_wr_req = 1; data_wr_type = TYPE_LINE; data_wr_addr = 32'h0000_3000;
    tick; data_wr_req = 0; #1;
    checks++;
    if ({rd_state, wr_state} !== {R_R, W_SEND}) begin
      errors++; $display("FAIL rstmid_setup: got %b exp %b", {rd_state, wr_state}, {R_R, W_SEND});
    end
    rst = 1; rvalid = 1; rid = 0; awready = 1; wready = 1; bvalid = 1;
    tick;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_ret_valid, data_ret_valid,
         inst_rd_rdy, data_rd_rdy, data_wr_rdy} !== 10'b0) begin
      errors++; $display("FAIL rstmid_outputs: some valid/ready high during rst");
    end
    rst = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; #1;
    checks++;
    if ({inst_rd_rdy, data_wr_rdy, rd_state, wr_state} !== {2'b11, R_IDLE, W_IDLE}) begin
      errors++; $display("FAIL rstmid_release: got %b exp %b", {inst_rd_rdy, data_wr_rdy, rd_state, wr_state}, {2'b11, R_IDLE, W_IDLE});
    end
  endtask

  initial begin
    test_reset;
    test_inst_line;
    test_arb;
    test_write_line;
    test_raw;
    test_byte_write;
    test_reset_mid;
    repeat (2) tick;
    checks++;
    if ({inst_q.size(), data_q.size(), w_q.size()} !== 96'd0) begin
      errors++; $display("FAIL queues_drained: inst=%0d data=%0d w=%0d exp 0", inst_q.size(), data_q.size(), w_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
